// File: rtl/song_playback_controller.sv
// song_playback_controller
// Sequences playback of one song through musical_score_loader: latches the
// song choice, holds the loader in reset while loading, generates the
// per-song beat, runs a count-in, handles pause/resume/stop, and reports
// completion once the end marker has scrolled through the drain window.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   start               one-cycle request to begin (IDLE only)
//   pause_toggle        one-cycle pause/resume request
//   stop                one-cycle abort request
//   song_sel            song choice, sampled on an accepted start
//   newest_note[3:0]    loader's newest note; 4'hF marks end of song
//   loader_reset        active-high reset to the loader
//   song_id             latched song choice
//   tempo[25:0]         beat period for the latched song
//   beat                one-cycle scroll strobe
//   count_in_beat       one-cycle count-in strobe
//   state[2:0]          encoded FSM state
//   beats_played[11:0]  saturating scroll-beat count
//   song_done           one-cycle completion pulse
module song_playback_controller #(
    parameter logic [25:0] TEMPO_0        = 26'd16250000,
    parameter logic [25:0] TEMPO_1        = 26'd32500000,
    parameter int          LOAD_CYCLES    = 4,
    parameter int          COUNT_IN_BEATS = 4,
    parameter int          DRAIN_BEATS    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pause_toggle,
    input  logic        stop,
    input  logic        song_sel,
    input  logic [3:0]  newest_note,
    output logic        loader_reset,
    output logic        song_id,
    output logic [25:0] tempo,
    output logic        beat,
    output logic        count_in_beat,
    output logic [2:0]  state,
    output logic [11:0] beats_played,
    output logic        song_done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_COUNTIN = 3'd2;
    localparam logic [2:0] S_PLAYING = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_PAUSED  = 3'd6;

    localparam logic [15:0] LOAD_LAST  = 16'(LOAD_CYCLES - 1);
    localparam logic [15:0] CIN_LAST   = 16'(COUNT_IN_BEATS - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_BEATS - 1);

    logic [2:0]  saved_state;
    logic [25:0] beat_cnt;
    logic [15:0] load_cnt;
    logic [15:0] cin_cnt;
    logic [15:0] drain_cnt;

    logic [2:0]  eff_state;
    logic [2:0]  adv_state;
    logic [2:0]  next_state;
    logic        active;
    logic        tick;
    logic        terminal;
    logic        fire;
    logic        end_mark;
    logic        accept;

    assign tempo        = song_id ? TEMPO_1 : TEMPO_0;
    assign loader_reset = (state == S_IDLE) || (state == S_LOAD);

    always_comb begin
        active    = (state == S_COUNTIN) || (state == S_PLAYING) || (state == S_DRAIN);
        // While paused, the resume cycle behaves as a cycle of the saved state.
        eff_state = (state == S_PAUSED) ? saved_state : state;
        // The pause cycle itself does not count; the resume cycle does, so a
        // terminal count suppressed by the pause fires right after resume.
        tick      = !stop && ((active && !pause_toggle) || (state == S_PAUSED && pause_toggle));
        terminal  = (beat_cnt == tempo - 26'd1);
        fire      = tick && terminal;
        end_mark  = (eff_state == S_PLAYING) && (newest_note == 4'hF);
        accept    = (state == S_IDLE) && start && !stop && !pause_toggle;

        adv_state = eff_state;
        if (fire && eff_state == S_COUNTIN && cin_cnt == CIN_LAST)
            adv_state = S_PLAYING;
        if (fire && eff_state == S_DRAIN && drain_cnt == DRAIN_LAST)
            adv_state = S_DONE;
        if (end_mark)
            adv_state = S_DRAIN;

        next_state = state;
        if (stop && state != S_IDLE) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (accept) next_state = S_LOAD;
                S_LOAD:    if (load_cnt == LOAD_LAST) next_state = S_COUNTIN;
                S_COUNTIN,
                S_PLAYING,
                S_DRAIN:   next_state = pause_toggle ? S_PAUSED : adv_state;
                S_PAUSED:  if (pause_toggle) next_state = adv_state;
                S_DONE:    next_state = S_IDLE;
                default:   next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            saved_state   <= S_IDLE;
            song_id       <= 1'b0;
            beat_cnt      <= '0;
            load_cnt      <= '0;
            cin_cnt       <= '0;
            drain_cnt     <= '0;
            beat          <= 1'b0;
            count_in_beat <= 1'b0;
            beats_played  <= '0;
            song_done     <= 1'b0;
        end else begin
            state         <= next_state;
            beat          <= fire && (eff_state == S_PLAYING || eff_state == S_DRAIN);
            count_in_beat <= fire && (eff_state == S_COUNTIN);
            song_done     <= (next_state == S_DONE);

            if (active && pause_toggle && !stop)
                saved_state <= state;

            if (accept) begin
                song_id      <= song_sel;
                beats_played <= '0;
            end else if (fire && (eff_state == S_PLAYING || eff_state == S_DRAIN)
                         && beats_played != 12'hFFF) begin
                beats_played <= beats_played + 12'd1;
            end

            if (state == S_IDLE || state == S_LOAD)
                beat_cnt <= '0;
            else if (tick)
                beat_cnt <= terminal ? 26'd0 : beat_cnt + 26'd1;

            load_cnt <= (state == S_LOAD) ? load_cnt + 16'd1 : 16'd0;

            if (state == S_LOAD)
                cin_cnt <= '0;
            else if (fire && eff_state == S_COUNTIN)
                cin_cnt <= cin_cnt + 16'd1;

            if (tick && end_mark)
                drain_cnt <= '0;
            else if (fire && eff_state == S_DRAIN)
                drain_cnt <= drain_cnt + 16'd1;
        end
    end

endmodule
